// File: rtl/free_list_pkg.sv
// ---------------------------------------------------------------------------
// free_list_pkg
//   Shared sizing constants and tag/pointer/count types for the physical
//   register free list. Imported by free_list and its testbench.
//   Contents:
//     N_WAY       superscalar width (dispatch and retire ways)
//     N_PHYS_REG  physical registers; tag 0 is the reserved "no tag"
//     N_ARCH_REG  architectural registers, mapped to tags 0..N_ARCH_REG-1
//                 out of reset
//     TAG_BITS    physical tag width
//     N_FL        free list depth (physical minus architectural)
//     PTR_BITS    head/tail pointer width
//     CNT_BITS    occupancy count width (must hold N_FL itself)
//     AVAIL_BITS  width of free_avail (holds 0..N_WAY)
//     RANK_BITS   width of a per-way prefix count (holds 0..N_WAY)
// ---------------------------------------------------------------------------
package free_list_pkg;

    localparam int N_WAY      = 2;
    localparam int N_PHYS_REG = 64;
    localparam int N_ARCH_REG = 32;
    localparam int TAG_BITS   = $clog2(N_PHYS_REG);
    localparam int N_FL       = N_PHYS_REG - N_ARCH_REG;
    localparam int PTR_BITS   = $clog2(N_FL);
    localparam int CNT_BITS   = $clog2(N_FL) + 1;
    localparam int AVAIL_BITS = $clog2(N_WAY) + 1;
    localparam int RANK_BITS  = $clog2(N_WAY + 1);

    typedef logic [TAG_BITS-1:0] tag_t;
    typedef logic [PTR_BITS-1:0] ptr_t;
    typedef logic [CNT_BITS-1:0] cnt_t;

    // Tag 0 means "no destination register" and is never recycled.
    localparam tag_t NULL_TAG = '0;

endpackage

// File: rtl/fl_way_compact.sv
// ---------------------------------------------------------------------------
// fl_way_compact
//   Per-way prefix counter used to compact sparse per-way requests into
//   consecutive FIFO slots. For each way k, rank[k] is the number of
//   requesting ways strictly below k, so the k-th way's slot offset is
//   rank[k]. total is the number of requesting ways.
//   Used once for allocation requests and once for retire pushes.
//   Ports:
//     req    in   N_WAY               per-way request bits
//     rank   out  N_WAY x RANK_BITS   count of requests in lower ways
//     total  out  RANK_BITS           count of all requests
// ---------------------------------------------------------------------------
module fl_way_compact #(
    parameter int N_WAY     = 2,
    parameter int RANK_BITS = $clog2(N_WAY + 1)
) (
    input  logic [N_WAY-1:0]                req,
    output logic [N_WAY-1:0][RANK_BITS-1:0] rank,
    output logic [RANK_BITS-1:0]            total
);

    // Running sum across ways in ascending order; each way sees the sum
    // before its own bit is added.
    always_comb begin
        logic [RANK_BITS-1:0] acc;
        acc  = '0;
        rank = '0;
        for (int k = 0; k < N_WAY; k++) begin
            rank[k] = acc;
            acc     = acc + RANK_BITS'(req[k]);
        end
        total = acc;
    end

endmodule

// File: rtl/free_list.sv
// ---------------------------------------------------------------------------
// free_list
//   Physical register free list for the out-of-order core. A circular FIFO
//   of free physical tags: ROB retirement pushes the old tag of each
//   retiring instruction at the tail, and rename/dispatch pops new
//   destination tags from the head, up to N_WAY per cycle in way order.
//   Ports:
//     clock         in   rising-edge core clock
//     reset         in   synchronous, active-low (0 = reset)
//     retire_valid  in   per-way ROB retire valid
//     retire_told   in   per-way old tag freed by retirement (way k at
//                        bits [k*TAG_BITS +: TAG_BITS]); tag 0 is ignored
//     alloc_req     in   per-way request for a new destination tag
//     alloc_valid   out  per-way grant this cycle
//     alloc_tag     out  per-way granted tag, 0 when not granted
//     free_avail    out  min(free_count, N_WAY), for dispatch stalling
//     free_count    out  number of tags currently held
//     overflow_err  out  sticky; a push was attempted with the list full
// ---------------------------------------------------------------------------
module free_list
    import free_list_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_WAY-1:0]          retire_valid,
    input  logic [N_WAY*TAG_BITS-1:0] retire_told,
    input  logic [N_WAY-1:0]          alloc_req,
    output logic [N_WAY-1:0]          alloc_valid,
    output logic [N_WAY*TAG_BITS-1:0] alloc_tag,
    output logic [AVAIL_BITS-1:0]     free_avail,
    output logic [CNT_BITS-1:0]       free_count,
    output logic                      overflow_err
);

    tag_t entries [N_FL];
    ptr_t head;
    ptr_t tail;
    cnt_t count;
    logic err;

    logic [N_WAY-1:0]                push_req;
    logic [N_WAY-1:0]                grant;
    logic [N_WAY-1:0]                accept;
    logic [N_WAY-1:0][RANK_BITS-1:0] alloc_rank;
    logic [N_WAY-1:0][RANK_BITS-1:0] push_rank;
    logic [RANK_BITS-1:0]            req_total;
    logic [RANK_BITS-1:0]            push_total;

    cnt_t grant_total;
    cnt_t room;
    cnt_t push_count;
    logic over;

    // A retiring way only frees something when it carries a real tag.
    always_comb begin
        push_req = '0;
        for (int k = 0; k < N_WAY; k++) begin
            push_req[k] = retire_valid[k] &&
                          (retire_told[k*TAG_BITS +: TAG_BITS] != NULL_TAG);
        end
    end

    fl_way_compact #(
        .N_WAY     (N_WAY),
        .RANK_BITS (RANK_BITS)
    ) u_alloc_compact (
        .req   (alloc_req),
        .rank  (alloc_rank),
        .total (req_total)
    );

    fl_way_compact #(
        .N_WAY     (N_WAY),
        .RANK_BITS (RANK_BITS)
    ) u_push_compact (
        .req   (push_req),
        .rank  (push_rank),
        .total (push_total)
    );

    // Grants and pushes for this cycle. The requesting way with rank n is
    // served only while n < count, so grants = min(requests, count). Slots
    // popped this cycle are reusable by this cycle's pushes, which is why
    // room includes the grants; pushes beyond room are dropped from the
    // highest ways and flag the sticky error. Nothing is granted while
    // reset is held.
    always_comb begin
        grant       = '0;
        accept      = '0;
        grant_total = '0;
        if (reset) begin
            for (int k = 0; k < N_WAY; k++) begin
                grant[k] = alloc_req[k] && (cnt_t'(alloc_rank[k]) < count);
            end
            grant_total = (cnt_t'(req_total) < count) ? cnt_t'(req_total) : count;
        end
        room       = cnt_t'(N_FL) - count + grant_total;
        over       = cnt_t'(push_total) > room;
        push_count = over ? room : cnt_t'(push_total);
        for (int k = 0; k < N_WAY; k++) begin
            accept[k] = push_req[k] && (cnt_t'(push_rank[k]) < room);
        end
    end

    // FIFO state. Reset restores the initial free set N_ARCH_REG..N_PHYS_REG-1
    // and discards whatever was happening that cycle. Pointers are exactly
    // PTR_BITS wide, so wrap-around is the natural modulo of the adder.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N_FL; i++) begin
                entries[i] <= tag_t'(N_ARCH_REG + i);
            end
            head  <= '0;
            tail  <= '0;
            count <= cnt_t'(N_FL);
            err   <= 1'b0;
        end else begin
            for (int k = 0; k < N_WAY; k++) begin
                if (accept[k]) begin
                    entries[tail + ptr_t'(push_rank[k])] <=
                        retire_told[k*TAG_BITS +: TAG_BITS];
                end
            end
            head  <= head + ptr_t'(grant_total);
            tail  <= tail + ptr_t'(push_count);
            count <= count - grant_total + push_count;
            err   <= err | over;
        end
    end

    // Granted tags are read straight from registered state; tags freed in
    // the same cycle only become visible after the edge.
    always_comb begin
        alloc_valid = grant;
        alloc_tag   = '0;
        for (int k = 0; k < N_WAY; k++) begin
            if (grant[k]) begin
                alloc_tag[k*TAG_BITS +: TAG_BITS] = entries[head + ptr_t'(alloc_rank[k])];
            end
        end
    end

    always_comb begin
        free_avail   = (count >= cnt_t'(N_WAY)) ? AVAIL_BITS'(N_WAY) : AVAIL_BITS'(count);
        free_count   = count;
        overflow_err = err;
    end

endmodule

// File: tb/tb_free_list.sv
// ---------------------------------------------------------------------------
// tb_free_list
//   Randomised and directed testbench for free_list. The reference model is
//   a plain queue of free tags: grants pop from the front in way order,
//   retirements append at the back, capacity is N_FL.
// ---------------------------------------------------------------------------
module tb_free_list;
    import free_list_pkg::*;

    logic                      clock = 1'b0;
    logic                      reset = 1'b0;
    logic [N_WAY-1:0]          retire_valid = '0;
    logic [N_WAY*TAG_BITS-1:0] retire_told = '0;
    logic [N_WAY-1:0]          alloc_req = '0;
    logic [N_WAY-1:0]          alloc_valid;
    logic [N_WAY*TAG_BITS-1:0] alloc_tag;
    logic [AVAIL_BITS-1:0]     free_avail;
    logic [CNT_BITS-1:0]       free_count;
    logic                      overflow_err;

    free_list dut (
        .clock        (clock),
        .reset        (reset),
        .retire_valid (retire_valid),
        .retire_told  (retire_told),
        .alloc_req    (alloc_req),
        .alloc_valid  (alloc_valid),
        .alloc_tag    (alloc_tag),
        .free_avail   (free_avail),
        .free_count   (free_count),
        .overflow_err (overflow_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int valid;
        int tag [N_WAY];
        int count;
        int avail;
        int err;
        bit check_state;
    } exp_t;

    exp_t exp_q[$];
    int   model_q[$];
    int   model_err;
    int   errors = 0;
    int   checks = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs and records what the free list must show
    // during that cycle, then advances the reference model past the edge.
    task automatic applyStimulus(input bit rst_n, input logic [N_WAY-1:0] rv,
                                 input int told0, input int told1,
                                 input logic [N_WAY-1:0] areq);
        exp_t e;
        int   n;
        int   told [N_WAY];
        @(negedge clock);
        reset        = rst_n;
        retire_valid = rv;
        retire_told  = {TAG_BITS'(told1), TAG_BITS'(told0)};
        alloc_req    = areq;
        told[0]      = told0;
        told[1]      = told1;
        e.valid       = 0;
        e.count       = 0;
        e.avail       = 0;
        e.err         = 0;
        e.check_state = 1'b0;
        for (int k = 0; k < N_WAY; k++) e.tag[k] = 0;
        if (!rst_n) begin
            model_q = {};
            for (int i = 0; i < N_FL; i++) model_q.push_back(N_ARCH_REG + i);
            model_err = 0;
        end else begin
            e.check_state = 1'b1;
            e.count = model_q.size();
            e.avail = (model_q.size() < N_WAY) ? model_q.size() : N_WAY;
            e.err   = model_err;
            n = 0;
            for (int k = 0; k < N_WAY; k++) begin
                if (areq[k] && n < model_q.size()) begin
                    e.valid  = e.valid | (1 << k);
                    e.tag[k] = model_q[n];
                    n++;
                end
            end
            repeat (n) void'(model_q.pop_front());
            for (int k = 0; k < N_WAY; k++) begin
                if (rv[k] && told[k] != 0) begin
                    if (model_q.size() < N_FL) model_q.push_back(told[k]);
                    else model_err = 1;
                end
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compares whatever the free list presents against the
    // oldest outstanding expectation, independently of the driver.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("alloc_valid", int'(alloc_valid), e.valid);
                for (int k = 0; k < N_WAY; k++) begin
                    checkOutput($sformatf("alloc_tag[%0d]", k),
                                int'(alloc_tag[k*TAG_BITS +: TAG_BITS]), e.tag[k]);
                end
                if (e.check_state) begin
                    checkOutput("free_count", int'(free_count), e.count);
                    checkOutput("free_avail", int'(free_avail), e.avail);
                    checkOutput("overflow_err", int'(overflow_err), e.err);
                end
            end
        end
    end

    initial begin
        int t0;
        int t1;
        int wait_cycles;
        $display("[TB] free_list test start");

        // Reset, then two-wide allocation: {33,32} then {35,34}.
        applyStimulus(0, 2'b00, 0, 0, 2'b11);
        applyStimulus(0, 2'b00, 0, 0, 2'b00);
        applyStimulus(1, 2'b00, 0, 0, 2'b11);
        applyStimulus(1, 2'b00, 0, 0, 2'b11);

        // Drain to empty, then keep asking.
        repeat (14) applyStimulus(1, 2'b00, 0, 0, 2'b11);
        applyStimulus(1, 2'b00, 0, 0, 2'b11);
        applyStimulus(1, 2'b00, 0, 0, 2'b10);

        // Refill two tags and hand them out one at a time.
        applyStimulus(1, 2'b11, 5, 9, 2'b00);
        applyStimulus(1, 2'b00, 0, 0, 2'b01);
        applyStimulus(1, 2'b00, 0, 0, 2'b01);
        applyStimulus(1, 2'b00, 0, 0, 2'b01);

        // Single tag left; a same-cycle free must not be granted yet.
        applyStimulus(1, 2'b01, 7, 0, 2'b00);
        applyStimulus(1, 2'b01, 12, 0, 2'b11);
        applyStimulus(1, 2'b00, 0, 0, 2'b11);

        // A zero old tag is not a real free.
        applyStimulus(1, 2'b11, 20, 0, 2'b00);
        applyStimulus(1, 2'b10, 0, 0, 2'b01);
        applyStimulus(1, 2'b00, 0, 0, 2'b11);

        // Overflow on a full list, stickiness, then reset mid-stream.
        applyStimulus(0, 2'b00, 0, 0, 2'b00);
        applyStimulus(1, 2'b01, 40, 0, 2'b00);
        applyStimulus(1, 2'b11, 41, 42, 2'b01);
        applyStimulus(1, 2'b00, 0, 0, 2'b11);
        applyStimulus(0, 2'b11, 3, 4, 2'b11);
        applyStimulus(1, 2'b00, 0, 0, 2'b11);
        applyStimulus(1, 2'b00, 0, 0, 2'b11);

        // Randomised phases alternating between draining and refilling so
        // both the empty and full boundaries, and pointer wrap, recur.
        for (int blk = 0; blk < 8; blk++) begin
            for (int c = 0; c < 200; c++) begin
                logic [N_WAY-1:0] rv;
                logic [N_WAY-1:0] areq;
                bit               rst_n;
                rst_n = ($urandom_range(0, 199) != 0);
                rv    = N_WAY'($urandom_range(0, 3));
                areq  = N_WAY'($urandom_range(0, 3));
                if (blk % 2 == 0) begin
                    if ($urandom_range(0, 3) != 0) rv = '0;
                end else begin
                    if ($urandom_range(0, 3) != 0) areq = '0;
                end
                t0 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, N_PHYS_REG - 1));
                t1 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, N_PHYS_REG - 1));
                applyStimulus(rst_n, rv, t0, t1, areq);
            end
        end

        // Let the monitor consume every outstanding expectation.
        @(negedge clock);
        retire_valid = '0;
        alloc_req    = '0;
        wait_cycles  = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(negedge clock);
            wait_cycles++;
        end
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
